// File: rtl/regression_pkg.sv
// Shared types and sizing for the regression residual stage.
package regression_pkg;

   localparam int DW_DEF   = 20;
   localparam int FRAC_DEF = 10;
   localparam int AW_DEF   = 8;
   localparam int N_DEF    = 150;

   // Residual width: a full 2*DW product plus one bit of headroom for the subtract
   localparam int EW   = 2*DW_DEF + 1;
   // Accumulator width: residual width plus enough bits to sum 2^AW residuals
   localparam int SAEW = EW + AW_DEF;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      OUT,
      DONE
   } state_t;

   function automatic int ew_of(input int dw);
      return 2*dw + 1;
   endfunction

   function automatic int saew_of(input int dw, input int aw);
      return 2*dw + 1 + aw;
   endfunction

endpackage

// File: rtl/regression_error_unit_if.sv
// Sample-memory read port plus the residual valid/ready stream.
interface regression_error_unit_if #(
   parameter int DW = 20,
   parameter int AW = 8
);
   localparam int EW = 2*DW + 1;

   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic signed [DW-1:0] x_in;
   logic signed [DW-1:0] y_in;
   logic signed [EW-1:0] err;
   logic [AW-1:0]        err_idx;
   logic                 err_valid;
   logic                 err_ready;

   // master: the error unit (reads memory, produces residuals)
   modport master (
      output rd_en, rd_addr, err, err_idx, err_valid,
      input  x_in, y_in, err_ready
   );

   // slave: the memory and the residual consumer
   modport slave (
      input  rd_en, rd_addr, err, err_idx, err_valid,
      output x_in, y_in, err_ready
   );
endinterface

// File: rtl/residual_datapath.sv
// Coefficient hold, residual compute and SAE accumulation, driven by FSM strobes.
module residual_datapath
   import regression_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int AW   = AW_DEF,
   localparam int EWL   = 2*DW + 1,
   localparam int SAEWL = 2*DW + 1 + AW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,     // accepted start: latch coefficients, clear
   input  logic                    compute,  // sample data present on x_in/y_in
   input  logic                    accum,    // residual handshake
   input  logic signed [DW-1:0]    b0_in,
   input  logic signed [DW-1:0]    b1_in,
   input  logic signed [DW-1:0]    x_in,
   input  logic signed [DW-1:0]    y_in,
   output logic signed [EWL-1:0]   err,
   output logic [SAEWL-1:0]        sae
);

   logic signed [DW-1:0]    b0_q, b1_q;
   logic signed [2*DW-1:0]  b1_ext, x_ext, prod, scaled;
   logic signed [EWL-1:0]   b0_ext, y_ext, scl_ext, res;
   logic [EWL-1:0]          mag;

   // Operands widened up front so the product is the exact 2*DW result
   assign b1_ext  = {{DW{b1_q[DW-1]}}, b1_q};
   assign x_ext   = {{DW{x_in[DW-1]}}, x_in};
   assign prod    = b1_ext * x_ext;
   assign scaled  = prod >>> FRAC;
   assign b0_ext  = {{(EWL-DW){b0_q[DW-1]}}, b0_q};
   assign y_ext   = {{(EWL-DW){y_in[DW-1]}}, y_in};
   assign scl_ext = {scaled[2*DW-1], scaled};
   assign res     = y_ext - (b0_ext + scl_ext);

   // Most-negative err cannot be reached, so plain negation is a safe magnitude
   assign mag = err[EWL-1] ? EWL'(-err) : EWL'(err);

   // Coefficients are frozen for the whole run once start is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         b0_q <= '0;
         b1_q <= '0;
      end else if (load) begin
         b0_q <= b0_in;
         b1_q <= b1_in;
      end
   end

   // Residual register: held steady while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst || load) err <= '0;
      else if (compute) err <= res;
   end

   // Sum of |err| over accepted residuals only
   always_ff @(posedge clk) begin
      if (rst || load) sae <= '0;
      else if (accum) sae <= sae + {{AW{1'b0}}, mag};
   end

endmodule

// File: rtl/regression_error_unit.sv
// Rescans sample memory with final B0/B1 and streams residuals plus running SAE.
module regression_error_unit
   import regression_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int FRAC      = FRAC_DEF,
   parameter int N_SAMPLES = N_DEF,
   parameter int AW        = AW_DEF,
   localparam int SAEWL    = 2*DW + 1 + AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic signed [DW-1:0]  B0,
   input  logic signed [DW-1:0]  B1,
   regression_error_unit_if.master bus,
   output logic [SAEWL-1:0]      sae,
   output logic                  busy,
   output logic                  done
);

   state_t        state, state_nx;
   logic [AW-1:0] idx;
   logic          load, compute, accum, last;

   assign last         = (idx == AW'(N_SAMPLES - 1));
   assign bus.rd_addr  = bus.rd_en ? idx : '0;
   assign bus.err_idx  = idx;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Sample index: cleared on start, advanced on every non-final handshake
   always_ff @(posedge clk) begin
      if (rst || load)        idx <= '0;
      else if (accum && !last) idx <= idx + 1'b1;
   end

   // Next state, handshake outputs and datapath strobes
   always_comb begin
      state_nx      = state;
      busy          = 1'b1;
      done          = 1'b0;
      bus.rd_en     = 1'b0;
      bus.err_valid = 1'b0;
      load          = 1'b0;
      compute       = 1'b0;
      accum         = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               load     = 1'b1;
               state_nx = READ;
            end
         end
         READ: begin
            bus.rd_en = 1'b1;
            state_nx  = LATCH;
         end
         LATCH: begin
            compute  = 1'b1;
            state_nx = OUT;
         end
         OUT: begin
            bus.err_valid = 1'b1;
            if (bus.err_ready) begin
               accum    = 1'b1;
               state_nx = last ? DONE : READ;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   residual_datapath #(
      .DW   (DW),
      .FRAC (FRAC),
      .AW   (AW)
   ) u_dp (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .compute (compute),
      .accum   (accum),
      .b0_in   (B0),
      .b1_in   (B1),
      .x_in    (bus.x_in),
      .y_in    (bus.y_in),
      .err     (bus.err),
      .sae     (sae)
   );

endmodule

// File: tb/tb_regression_error_unit.sv
// Scoreboard bench: two instances (N_SAMPLES=2 and N_SAMPLES=1) with small sample memories.
module tb_regression_error_unit;

   localparam int DW   = 20;
   localparam int FRAC = 10;
   localparam int AW   = 8;
   localparam int SAEW = 2*DW + 1 + AW;

   typedef struct {
      longint err;
      int     idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start_a, start_b;
   logic signed [DW-1:0] b0, b1;
   logic [SAEW-1:0] sae_a, sae_b;
   logic busy_a, busy_b, done_a, done_b;

   logic signed [DW-1:0] mxa [4];
   logic signed [DW-1:0] mya [4];
   logic signed [DW-1:0] mxb, myb;

   exp_t qa[$], qb[$];
   int n_chk = 0;
   int n_err = 0;

   regression_error_unit_if #(.DW(DW), .AW(AW)) bus_a ();
   regression_error_unit_if #(.DW(DW), .AW(AW)) bus_b ();

   regression_error_unit #(.DW(DW), .FRAC(FRAC), .N_SAMPLES(2), .AW(AW)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .B0(b0), .B1(b1),
      .bus(bus_a), .sae(sae_a), .busy(busy_a), .done(done_a)
   );

   regression_error_unit #(.DW(DW), .FRAC(FRAC), .N_SAMPLES(1), .AW(AW)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .B0(b0), .B1(b1),
      .bus(bus_b), .sae(sae_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Sample memories: data appears the cycle after rd_en
   always @(posedge clk) begin
      if (bus_a.rd_en) begin
         bus_a.x_in <= mxa[bus_a.rd_addr[1:0]];
         bus_a.y_in <= mya[bus_a.rd_addr[1:0]];
      end
      if (bus_b.rd_en) begin
         bus_b.x_in <= mxb;
         bus_b.y_in <= myb;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int sel, input int c0, input int exp_c, input string nm);
      int c;
      c = c0;
      while (!(sel != 0 ? done_b : done_a) && c < 60) begin
         tick();
         c++;
      end
      chk(nm, (sel != 0 ? done_b : done_a) ? c : -1, exp_c);
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic pulse_start_b();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
   endtask

   // Scoreboard monitor, instance A
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst && bus_a.err_valid && bus_a.err_ready) begin
         if (qa.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_a_unexpected: got err %0d idx %0d expected none",
                     bus_a.err, bus_a.err_idx);
         end else begin
            e = qa.pop_front();
            chk("sb_a_err", longint'(bus_a.err), e.err);
            chk("sb_a_idx", longint'(bus_a.err_idx), longint'(e.idx));
         end
      end
   end

   // Scoreboard monitor, instance B
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst && bus_b.err_valid && bus_b.err_ready) begin
         if (qb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_b_unexpected: got err %0d idx %0d expected none",
                     bus_b.err, bus_b.err_idx);
         end else begin
            e = qb.pop_front();
            chk("sb_b_err", longint'(bus_b.err), e.err);
            chk("sb_b_idx", longint'(bus_b.err_idx), longint'(e.idx));
         end
      end
   end

   initial begin : stim
      bit seen;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; b0 = '0; b1 = '0;
      bus_a.err_ready = 1'b1; bus_b.err_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin mxa[i] = '0; mya[i] = '0; end
      mxb = '0; myb = '0;
      repeat (2) tick();
      chk("rst_busy_a", busy_a, 0);
      chk("rst_rd_en_a", bus_a.rd_en, 0);
      chk("rst_valid_a", bus_a.err_valid, 0);
      chk("rst_err_a", longint'(bus_a.err), 0);
      chk("rst_sae_a", longint'(sae_a), 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_busy_b", busy_b, 0);
      rst = 1'b0;
      tick();

      // single sample, N_SAMPLES=1: err = 8192 - (1024 + 6144) = 1024
      b0 = 1024; b1 = 2048; mxb = 3072; myb = 8192;
      qb.push_back('{1024, 0});
      pulse_start_b();
      chk("n1_rd_en_c1", bus_b.rd_en, 1);
      chk("n1_rd_addr_c1", longint'(bus_b.rd_addr), 0);
      tick();
      chk("n1_valid_c2", bus_b.err_valid, 0);
      tick();
      chk("n1_valid_c3", bus_b.err_valid, 1);
      chk("n1_err_c3", longint'(bus_b.err), 1024);
      wait_done(1, 3, 4, "n1_done_cycle");
      chk("n1_sae", longint'(sae_b), 1024);
      tick();
      chk("n1_busy_after", busy_b, 0);
      chk("n1_done_pulse", done_b, 0);

      // two samples: errs 0 then -1024, done at cycle 7
      mxa[0] = 3072; mya[0] = 7168; mxa[1] = -1024; mya[1] = -2048;
      qa.push_back('{0, 0}); qa.push_back('{-1024, 1});
      pulse_start_a();
      wait_done(0, 1, 7, "n2_done_cycle");
      chk("n2_sae", longint'(sae_a), 1024);
      tick();
      chk("n2_busy_after", busy_a, 0);
      chk("n2_done_pulse", done_a, 0);
      chk("n2_sae_hold", longint'(sae_a), 1024);

      // back-pressure: err_ready low for 5 cycles in OUT of sample 0
      mya[0] = 8192;
      qa.push_back('{1024, 0}); qa.push_back('{-1024, 1});
      bus_a.err_ready = 1'b0;
      pulse_start_a();
      tick(); tick();
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", bus_a.err_valid, 1);
         chk("stall_rd_en", bus_a.rd_en, 0);
         chk("stall_err", longint'(bus_a.err), 1024);
         chk("stall_idx", longint'(bus_a.err_idx), 0);
         chk("stall_sae", longint'(sae_a), 0);
         tick();
      end
      bus_a.err_ready = 1'b1;
      chk("stall_valid_c8", bus_a.err_valid, 1);
      tick();
      chk("stall_valid_c9", bus_a.err_valid, 0);
      chk("stall_rd_en_c9", bus_a.rd_en, 1);
      chk("stall_sae_once", longint'(sae_a), 1024);
      wait_done(0, 9, 12, "stall_done_cycle");
      chk("stall_sae_final", longint'(sae_a), 2048);
      tick();

      // restart attempt mid-run with new coefficients is ignored
      mya[0] = 7168;
      qa.push_back('{0, 0}); qa.push_back('{-1024, 1});
      pulse_start_a();
      tick();
      b0 = 0; b1 = 0; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done(0, 3, 7, "restart_done_cycle");
      chk("restart_sae", longint'(sae_a), 1024);
      tick();
      chk("restart_busy_after", busy_a, 0);

      // fractional, negative coefficients: floor behaviour of the arithmetic shift
      b0 = 512; b1 = -1536;
      mxa[0] = 1001; mya[0] = -300; mxa[1] = -7; mya[1] = 5;
      qa.push_back('{690, 0}); qa.push_back('{-517, 1});
      pulse_start_a();
      wait_done(0, 1, 7, "frac_done_cycle");
      chk("frac_sae", longint'(sae_a), 1207);
      tick();

      // reset during LATCH of sample 1 aborts the run
      b0 = 1024; b1 = 2048;
      mxa[0] = 3072; mya[0] = 7168; mxa[1] = -1024; mya[1] = -2048;
      qa.push_back('{0, 0});
      pulse_start_a();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", busy_a, 0);
      chk("abort_rd_en", bus_a.rd_en, 0);
      chk("abort_valid", bus_a.err_valid, 0);
      chk("abort_err", longint'(bus_a.err), 0);
      chk("abort_idx", longint'(bus_a.err_idx), 0);
      chk("abort_sae", longint'(sae_a), 0);
      chk("abort_done", done_a, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (4) begin tick(); seen |= done_a; end
      chk("abort_no_done", seen, 0);
      qa.push_back('{0, 0}); qa.push_back('{-1024, 1});
      pulse_start_a();
      wait_done(0, 1, 7, "rerun_done_cycle");
      chk("rerun_sae", longint'(sae_a), 1024);
      tick();

      // start and reset together: reset wins
      rst = 1'b1; start_a = 1'b1;
      tick();
      rst = 1'b0; start_a = 1'b0;
      chk("rststart_busy", busy_a, 0);
      chk("rststart_rd_en", bus_a.rd_en, 0);
      tick();
      chk("rststart_busy_2", busy_a, 0);
      chk("rststart_rd_en_2", bus_a.rd_en, 0);

      // extreme operands exercise the full residual width
      b0 = 524287; b1 = -524288; mxb = -524288; myb = -524288;
      qb.push_back('{-269484031, 0});
      pulse_start_b();
      wait_done(1, 1, 4, "wide_done_cycle");
      chk("wide_sae", longint'(sae_b), 269484031);
      tick(); tick();

      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
